prog_spi_master: RTL and testbench
==================================

# prog_spi_master

Serial programming master that drives the SoC programming pins: PROG, BRSTn, HOLDn and MOSI, and samples MISO. It sits on the tester/FPGA side of the programming link, or in the chip-level bench, and shares CLK with the SoC. Bits move one per CLK cycle, MSB first. BRSTn pulses low for one cycle before each frame to resync the slave bit counter. The block converts a byte-wide valid/ready stream into framed serial transfers and returns the byte shifted in on MISO for each frame.

## Interface
- DATA_W, 8: bits per frame.
- SETUP_CYC, 4: CLK cycles PROG is held high before the first frame of a session; range 1..255.
- FRAME_GAP, 1: idle cycles after each frame; range 0..15.

- CLK  in  1  system clock; all logic on the rising edge.
- RSTn  in  1  reset, asynchronous, active-low.
- SESSION_EN  in  1  level; high requests a programming session.
- TX_DATA  in  DATA_W  byte to send.
- TX_VALID  in  1  TX_DATA valid.
- TX_READY  out  1  block accepts TX_DATA this cycle.
- RX_DATA  out  DATA_W  last byte captured from MISO.
- RX_VALID  out  1  one-cycle pulse; RX_DATA updated.
- HOLD_REQ  in  1  pause shifting.
- BUSY  out  1  state != IDLE.
- PROG  out  1  programming-mode enable to the SoC.
- BRSTn  out  1  frame sync, active-low.
- HOLDn  out  1  hold to the SoC, active-low.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

All outputs are registered.

## Operation
- **States**
  - IDLE: PROG=0. SESSION_EN=1 moves to SETUP.
  - SETUP: PROG=1 for SETUP_CYC cycles, then WAIT.
  - WAIT: PROG=1, TX_READY=1.
    - TX_VALID&TX_READY loads the TX shift register and moves to SYNC.
    - SESSION_EN=0 with no handshake moves to TEARDOWN. The handshake takes priority if both occur in the same cycle.
  - SYNC: one cycle, BRSTn=0, MOSI=0.
  - SHIFT: DATA_W bit cycles; in bit cycle k, MOSI=TX_DATA[DATA_W-1-k].
  - GAP: FRAME_GAP cycles, MOSI=0, then WAIT. When FRAME_GAP=0, SHIFT goes directly to WAIT.
  - TEARDOWN: one cycle, PROG=1, then IDLE with PROG=0.
- **MISO capture**
  - MISO is sampled at the rising edge that ends each bit cycle and shifted in MSB first.
  - After the last bit, RX_DATA holds the full byte and RX_VALID=1 for exactly one cycle: the first cycle after SHIFT (GAP, or WAIT if FRAME_GAP=0).
  - RX_DATA holds its value until the next frame completes.
- **HOLD_REQ**
  - Sampled only in SHIFT. While high, HOLDn=0 (registered, one-cycle latency), the bit counter freezes and MOSI holds its current bit. MISO is not sampled during frozen cycles.
  - Each cycle HOLD_REQ is high stretches the frame by one cycle.
  - Ignored in all other states: HOLDn=1.
- **SESSION_EN** falling outside WAIT never aborts anything. The current frame, including its GAP, completes. Teardown happens on reaching WAIT, unless a new handshake occurs in that cycle.
- **Reset**
  - RSTn low forces every register to its reset value immediately, in any state, including mid-frame. No partial RX_VALID is emitted.
  - State returns to IDLE.
- **Reset values**: PROG=0, BRSTn=1, HOLDn=1, MOSI=0, TX_READY=0, RX_VALID=0, RX_DATA=0, BUSY=0.

## Timing
- SESSION_EN rise at edge t: PROG=1 and BUSY=1 from t+1. The first WAIT cycle (TX_READY=1) is t+1+SETUP_CYC.
- Handshake at edge w: SYNC is cycle w+1 (BRSTn=0). Bit k is driven in cycle w+2+k. RX_VALID is high in cycle w+2+DATA_W.
- With TX_VALID held high, the handshake-to-handshake period is 2+DATA_W+FRAME_GAP cycles (11 with defaults).
- TX_READY is high only in WAIT. There is no combinational path from TX_VALID to TX_READY.
- Counters:
  - Bit counter is ceil(log2(DATA_W+1)) bits.
  - Setup counter is 8 bits.
  - Gap counter is 4 bits.
  - No wrap-around within a frame; counters reload on each entry to their state.

## Test plan
- **Reset values**: assert RSTn=0 with random inputs -> all outputs at their reset values. Release with SESSION_EN=0 -> IDLE, BUSY=0.
- **Single frame**: SESSION_EN=1, TX_DATA=0xA5, MISO drives 0x3C MSB first.
  - MOSI sequence 1,0,1,0,0,1,0,1.
  - BRSTn low exactly one cycle before bit 7.
  - RX_DATA=0x3C with RX_VALID one cycle, 10 cycles after the handshake.
- **Back-to-back**: 0x01 then 0x80 with TX_VALID held high -> handshakes 11 cycles apart; MOSI 00000001 then 10000000; two RX_VALID pulses.
- **HOLD_REQ**: HOLD_REQ=1 for 3 cycles starting at bit 4 of 0xC3 -> HOLDn low 3 cycles; frame is 3 cycles longer; MOSI and RX_DATA bit-exact (MISO=0x5A gives RX_DATA=0x5A).
- **Session drop mid-frame**: drop SESSION_EN at bit 2 -> frame completes, RX_VALID pulses, then GAP, WAIT, TEARDOWN; PROG=0 and BUSY=0 afterward.
- **Reset mid-frame**: pulse RSTn low at bit 5 -> outputs at reset values immediately, no RX_VALID. A new session then starts with a full SETUP_CYC delay.

Source files
------------

// File: rtl/prog_spi_master.sv
// Serial programming master: frames a byte stream onto PROG/BRSTn/HOLDn/MOSI,
// one bit per CLK, MSB first, and returns the byte captured on MISO per frame.
//
// state    | meaning
// IDLE     | no session, PROG low
// SETUP    | PROG high, waiting SETUP_CYC cycles before the first frame
// WAIT     | TX_READY high, waiting for a byte or for the session to end
// SYNC     | one-cycle BRSTn low pulse ahead of the frame
// SHIFT    | DATA_W bit cycles, stretched while HOLD_REQ is high
// GAP      | FRAME_GAP idle cycles after the frame
// TEARDOWN | last PROG-high cycle before returning to IDLE
module prog_spi_master #(
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 4,
  parameter int FRAME_GAP = 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              SESSION_EN,
  input  logic [DATA_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [DATA_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              HOLD_REQ,
  output logic              BUSY,
  output logic              PROG,
  output logic              BRSTn,
  output logic              HOLDn,
  output logic              MOSI,
  input  logic              MISO
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [7:0]       SETUP_LOAD = 8'(SETUP_CYC - 1);
  localparam logic [3:0]       GAP_LOAD   = 4'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LOAD   = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_WAIT,
    S_SYNC,
    S_SHIFT,
    S_GAP,
    S_TEARDOWN
  } state_t;

  state_t            state_q;
  logic [7:0]        setup_cnt_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [3:0]        gap_cnt_q;
  logic [DATA_W-1:0] tx_sr_q;
  logic [DATA_W-1:0] rx_sr_q;
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              prog_q;
  logic              brst_n_q;
  logic              hold_n_q;
  logic              mosi_q;
  logic [DATA_W-1:0] rx_shift_d;

  // Receive register with the current MISO bit appended at the LSB end.
  always_comb begin
    rx_shift_d = DATA_W'({rx_sr_q, MISO});
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      setup_cnt_q <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      prog_q      <= 1'b0;
      brst_n_q    <= 1'b1;
      hold_n_q    <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      brst_n_q   <= 1'b1;
      hold_n_q   <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (SESSION_EN) begin
            state_q     <= S_SETUP;
            setup_cnt_q <= SETUP_LOAD;
            prog_q      <= 1'b1;
            busy_q      <= 1'b1;
          end
        end

        S_SETUP: begin
          if (setup_cnt_q == '0) begin
            state_q    <= S_WAIT;
            tx_ready_q <= 1'b1;
          end else begin
            setup_cnt_q <= setup_cnt_q - 1'b1;
          end
        end

        // A pending byte wins over a session drop in the same cycle.
        S_WAIT: begin
          if (TX_VALID && tx_ready_q) begin
            state_q    <= S_SYNC;
            tx_ready_q <= 1'b0;
            tx_sr_q    <= TX_DATA;
            bit_cnt_q  <= BIT_LOAD;
            brst_n_q   <= 1'b0;
            mosi_q     <= 1'b0;
          end else if (!SESSION_EN) begin
            state_q    <= S_TEARDOWN;
            tx_ready_q <= 1'b0;
          end
        end

        S_SYNC: begin
          state_q <= S_SHIFT;
          mosi_q  <= tx_sr_q[DATA_W-1];
          tx_sr_q <= tx_sr_q << 1;
        end

        // Frozen cycles keep MOSI and the counter and skip the MISO sample.
        S_SHIFT: begin
          if (HOLD_REQ) begin
            hold_n_q <= 1'b0;
          end else begin
            rx_sr_q <= rx_shift_d;
            if (bit_cnt_q == '0) begin
              rx_data_q  <= rx_shift_d;
              rx_valid_q <= 1'b1;
              mosi_q     <= 1'b0;
              if (FRAME_GAP > 0) begin
                state_q   <= S_GAP;
                gap_cnt_q <= GAP_LOAD;
              end else begin
                state_q    <= S_WAIT;
                tx_ready_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q - 1'b1;
              mosi_q    <= tx_sr_q[DATA_W-1];
              tx_sr_q   <= tx_sr_q << 1;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q    <= S_WAIT;
            tx_ready_q <= 1'b1;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        S_TEARDOWN: begin
          state_q <= S_IDLE;
          prog_q  <= 1'b0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q    <= S_IDLE;
          prog_q     <= 1'b0;
          busy_q     <= 1'b0;
          tx_ready_q <= 1'b0;
          mosi_q     <= 1'b0;
        end
      endcase
    end
  end

  assign TX_READY = tx_ready_q;
  assign RX_DATA  = rx_data_q;
  assign RX_VALID = rx_valid_q;
  assign BUSY     = busy_q;
  assign PROG     = prog_q;
  assign BRSTn    = brst_n_q;
  assign HOLDn    = hold_n_q;
  assign MOSI     = mosi_q;

endmodule

// File: tb/tb_prog_spi_master.sv
// Bench for prog_spi_master: directed and random frames checked against a
// per-cycle expectation built from the frame rules (bits, holds, gap, teardown).
module tb_prog_spi_master;

  localparam int DATA_W    = 8;
  localparam int SETUP_CYC = 4;
  localparam int FRAME_GAP = 1;

  logic              CLK = 1'b0;
  logic              RSTn;
  logic              SESSION_EN;
  logic [DATA_W-1:0] TX_DATA;
  logic              TX_VALID;
  logic              TX_READY;
  logic [DATA_W-1:0] RX_DATA;
  logic              RX_VALID;
  logic              HOLD_REQ;
  logic              BUSY;
  logic              PROG;
  logic              BRSTn;
  logic              HOLDn;
  logic              MOSI;
  logic              MISO;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned cyc = 0;
  int unsigned sync_at = 0;
  int unsigned prev_sync = 0;

  prog_spi_master #(
    .DATA_W   (DATA_W),
    .SETUP_CYC(SETUP_CYC),
    .FRAME_GAP(FRAME_GAP)
  ) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .SESSION_EN(SESSION_EN),
    .TX_DATA   (TX_DATA),
    .TX_VALID  (TX_VALID),
    .TX_READY  (TX_READY),
    .RX_DATA   (RX_DATA),
    .RX_VALID  (RX_VALID),
    .HOLD_REQ  (HOLD_REQ),
    .BUSY      (BUSY),
    .PROG      (PROG),
    .BRSTn     (BRSTn),
    .HOLDn     (HOLDn),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_prog"},  32'(PROG),     0);
    chk({tag, "_brstn"}, 32'(BRSTn),    1);
    chk({tag, "_holdn"}, 32'(HOLDn),    1);
    chk({tag, "_mosi"},  32'(MOSI),     0);
    chk({tag, "_rdy"},   32'(TX_READY), 0);
    chk({tag, "_rxv"},   32'(RX_VALID), 0);
    chk({tag, "_rxd"},   32'(RX_DATA),  0);
    chk({tag, "_busy"},  32'(BUSY),     0);
  endtask

  // Raise SESSION_EN from IDLE; returns at the negedge of the first WAIT cycle.
  task automatic start_session();
    @(negedge CLK);
    SESSION_EN = 1'b1;
    @(posedge CLK);
    for (int i = 0; i < SETUP_CYC; i++) begin
      @(negedge CLK);
      chk("setup_prog", 32'(PROG), 1);
      chk("setup_busy", 32'(BUSY), 1);
      chk("setup_rdy",  32'(TX_READY), 0);
    end
    @(negedge CLK);
    chk("wait_rdy",  32'(TX_READY), 1);
    chk("wait_prog", 32'(PROG), 1);
  endtask

  // Entered and left at the negedge of a WAIT cycle. The slave returns rxb on
  // MISO; bit hold_bit is frozen for hold_len cycles; SESSION_EN drops at drop_bit.
  task automatic frame(input logic [DATA_W-1:0] tx, input logic [DATA_W-1:0] rxb,
                       input int hold_bit, input int hold_len, input int drop_bit,
                       input bit keep_valid);
    int h;
    int htot;
    htot = (hold_bit >= 0) ? hold_len : 0;
    TX_DATA  = tx;
    TX_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    prev_sync = sync_at;
    sync_at   = cyc;
    chk("sync_brstn", 32'(BRSTn), 0);
    chk("sync_mosi",  32'(MOSI), 0);
    chk("sync_rdy",   32'(TX_READY), 0);
    chk("sync_holdn", 32'(HOLDn), 1);
    chk("sync_prog",  32'(PROG), 1);
    TX_VALID = keep_valid;
    HOLD_REQ = 1'b0;
    MISO     = 1'($urandom);
    for (int k = 0; k < DATA_W; k++) begin
      h = (k == hold_bit) ? hold_len : 0;
      for (int j = 0; j <= h; j++) begin
        @(negedge CLK);
        chk("bit_mosi",  32'(MOSI), 32'(tx[DATA_W-1-k]));
        chk("bit_brstn", 32'(BRSTn), 1);
        chk("bit_holdn", 32'(HOLDn), (j >= 1) ? 0 : 1);
        chk("bit_rxv",   32'(RX_VALID), 0);
        chk("bit_rdy",   32'(TX_READY), 0);
        if (k == drop_bit && j == 0) SESSION_EN = 1'b0;
        HOLD_REQ = (j < h);
        MISO     = (j == h) ? rxb[DATA_W-1-k] : 1'($urandom);
      end
    end
    for (int g = 0; g < FRAME_GAP; g++) begin
      @(negedge CLK);
      if (g == 0) chk("rxv_latency", cyc - sync_at, DATA_W + 1 + htot);
      chk("gap_rxv",   32'(RX_VALID), (g == 0) ? 1 : 0);
      chk("gap_rxd",   32'(RX_DATA), 32'(rxb));
      chk("gap_mosi",  32'(MOSI), 0);
      chk("gap_holdn", 32'(HOLDn), 1);
      chk("gap_rdy",   32'(TX_READY), 0);
      HOLD_REQ = 1'($urandom);
      MISO     = 1'($urandom);
    end
    @(negedge CLK);
    chk("end_rdy",   32'(TX_READY), 1);
    chk("end_rxv",   32'(RX_VALID), 0);
    chk("end_rxd",   32'(RX_DATA), 32'(rxb));
    chk("end_holdn", 32'(HOLDn), 1);
    chk("end_prog",  32'(PROG), 1);
    HOLD_REQ = 1'b0;
  endtask

  // Entered at the negedge of a WAIT cycle with SESSION_EN and TX_VALID low.
  task automatic teardown_check();
    @(negedge CLK);
    chk("td_prog", 32'(PROG), 1);
    chk("td_busy", 32'(BUSY), 1);
    chk("td_rdy",  32'(TX_READY), 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      chk("idle_prog", 32'(PROG), 0);
      chk("idle_busy", 32'(BUSY), 0);
      chk("idle_rdy",  32'(TX_READY), 0);
    end
  endtask

  initial begin
    logic [DATA_W-1:0] rtx;
    logic [DATA_W-1:0] rrx;
    int hb;

    RSTn = 1'b0;
    SESSION_EN = 1'b0;
    TX_VALID = 1'b0;
    TX_DATA = '0;
    HOLD_REQ = 1'b0;
    MISO = 1'b0;

    // Reset with random inputs.
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      check_reset_vals("rst");
      SESSION_EN = 1'($urandom);
      TX_VALID   = 1'($urandom);
      HOLD_REQ   = 1'($urandom);
      MISO       = 1'($urandom);
      TX_DATA    = 8'($urandom);
    end
    @(negedge CLK);
    SESSION_EN = 1'b0;
    TX_VALID = 1'b0;
    HOLD_REQ = 1'b0;
    RSTn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("post_rst_busy", 32'(BUSY), 0);
      chk("post_rst_prog", 32'(PROG), 0);
    end

    // Single frame.
    start_session();
    frame(8'hA5, 8'h3C, -1, 0, -1, 1'b0);

    // Back-to-back with TX_VALID held.
    frame(8'h01, 8'($urandom), -1, 0, -1, 1'b1);
    frame(8'h80, 8'($urandom), -1, 0, -1, 1'b0);
    chk("b2b_period", sync_at - prev_sync, 2 + DATA_W + FRAME_GAP);

    // HOLD_REQ for 3 cycles at bit 4.
    frame(8'hC3, 8'h5A, 4, 3, -1, 1'b0);
    // Hold on the last bit.
    frame(8'h7E, 8'h81, DATA_W - 1, 2, -1, 1'b0);

    // Random frames.
    for (int n = 0; n < 12; n++) begin
      rtx = 8'($urandom);
      rrx = 8'($urandom);
      hb  = $urandom_range(0, 9);
      if (hb > DATA_W - 1) hb = -1;
      frame(rtx, rrx, hb, $urandom_range(1, 3), -1, 1'($urandom));
    end

    // Handshake wins over a simultaneous session drop.
    SESSION_EN = 1'b0;
    frame(8'($urandom), 8'($urandom), -1, 0, -1, 1'b0);
    teardown_check();

    // Session drop mid-frame.
    start_session();
    frame(8'($urandom), 8'($urandom), -1, 0, 2, 1'b0);
    teardown_check();

    // Reset mid-frame at bit 5.
    start_session();
    TX_DATA  = 8'($urandom);
    TX_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    TX_VALID = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      MISO = 1'($urandom);
    end
    RSTn = 1'b0;
    #1;
    check_reset_vals("midrst");
    SESSION_EN = 1'b0;
    @(negedge CLK);
    check_reset_vals("midrst_hold");
    RSTn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      chk("midrst_rxv",  32'(RX_VALID), 0);
      chk("midrst_busy", 32'(BUSY), 0);
    end
    start_session();
    frame(8'($urandom), 8'($urandom), -1, 0, -1, 1'b0);
    SESSION_EN = 1'b0;
    teardown_check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
